sram_axi4_tg: RTL and testbench
===============================

# sram_axi4_tg

Parametrised AXI4 master traffic generator for SRAM slaves. It issues incrementing bursts of a deterministic data pattern, reads them back, checks every beat, and reports pass/fail. It sits in the SRAM test harness in front of any AXI4 SRAM slave and supersedes the single-beat fixed-width master, adding burst length, width, transfer count and mode selection.

## Interface
Parameters:
- ADDR_W, 8: address width.
- DATA_W, 64: data width; power of two, 8..1024.
- BURST_LEN, 4: beats per burst, 1..256.
- NUM_XFER, 4: bursts per run, >= 1.
- BASE_ADDR, 8: first burst address; DATA_W/8-aligned.

Ports (one clock; reset is synchronous and active-high, port `i_areset`):
- i_aclk  in  1  clock.
- i_areset  in  1  synchronous active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_mode  in  2  0 write-only, 1 read-check-only, 2 all-writes-then-all-reads, 3 interleaved (write burst t, read burst t).
- o_awaddr / o_awlen / o_awsize / o_awburst / o_awvalid  out  ADDR_W/8/3/2/1; i_awready  in  1.
- o_wdata / o_wstrb / o_wlast / o_wvalid  out  DATA_W/DATA_W/8/1/1; i_wready  in  1.
- i_bvalid  in  1; i_bresp  in  2; o_bready  out  1.
- o_araddr / o_arlen / o_arsize / o_arburst / o_arvalid  out  ADDR_W/8/3/2/1; i_arready  in  1.
- i_rvalid  in  1; i_rdata  in  DATA_W; i_rresp  in  2; i_rlast  in  1; o_rready  out  1.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle pulse at end of run.
- o_err_cnt  out  16  data/rlast mismatches, saturating.
- o_resp_err  out  1  sticky: any nonzero BRESP/RRESP.

## Operation
- FSM states: IDLE, AW, W, B, AR, R, NEXT, DONE.
- IDLE + i_start: latch i_mode, clear the transfer index t, o_err_cnt and o_resp_err; go to AW (modes 0, 2, 3) or AR (mode 1).
- Burst t address: BASE_ADDR + t*BURST_LEN*(DATA_W/8), modulo 2^ADDR_W.
- Burst signals: len = BURST_LEN-1; size = log2(DATA_W/8); burst = INCR (2'b01).
- Beat data: the global beat index is k = t*BURST_LEN + beat, and the data is k+1 modulo 2^DATA_W. WSTRB is all ones.
- Channel sequence: AW handshake, then W beats (WLAST on beat BURST_LEN-1), then B. Read side: AR handshake, then R beats.
- R check: compare i_rdata against the expected pattern on every handshake. A data mismatch increments o_err_cnt. An rlast value differing from (beat == BURST_LEN-1) also increments o_err_cnt. The R state exits after BURST_LEN handshakes regardless of rlast.
- NEXT sequencing:
  - Modes 0 and 1: t++ until NUM_XFER, then DONE.
  - Mode 2: after the last write, reset t to 0 and run the reads.
  - Mode 3: W→B→AR→R per t.
- DONE: pulse o_done, return to IDLE.
- i_start while busy is ignored. Results hold until the next start.

## Timing
- Reset values: all valid/ready outputs, o_busy, o_done, o_resp_err = 0; o_err_cnt = 0; address/len/data outputs = 0.
- AWVALID/ARVALID rise the cycle after i_start is sampled. Each is held with stable payload until its handshake.
- WVALID holds until i_wready; the next beat is presented the following cycle, i.e. one beat per cycle under continuous ready.
- o_bready = 1 only in B; o_rready = 1 only in R.
- A response and its check are registered; o_err_cnt updates one cycle after the R handshake.
- o_done asserts one cycle after the final B (mode 0) or final R handshake; o_busy falls in that same cycle.
- o_err_cnt saturates at 16'hFFFF.
- Reset mid-burst: return to IDLE on the next edge with reset values. The bench must also reset the slave.

## Structure
- Package sram_axi4_pkg holds:
  - the state enum;
  - AXI_BURST_INCR and AXI_RESP_OKAY constants;
  - the mode enum;
  - the size function log2(DATA_W/8).
- One sub-module, sram_axi4_tg_gen, holds t and the beat counters and produces the address and the expected/write data. It is shared by the write and read paths.

## Test plan
- Mode 0, defaults, always-ready slave -> 4 bursts at addresses 8, 40, 72, 104; data 1..16; WLAST on beats 3/7/11/15; o_done after the 4th B.
- Mode 2 against a correct SRAM model -> reads return 1..16; o_err_cnt = 0; o_resp_err = 0.
- Mode 3 with a slave that corrupts beat 6 (returns 0) -> o_err_cnt = 1, o_done pulses once.
- Random ready backpressure on AW/W/AR/R in mode 2 -> payload stable while valid is high; same results as the no-backpressure run.
- BRESP = 2'b10 on burst 1 plus early RLAST on beat 2 -> o_resp_err = 1 and o_err_cnt increments for rlast.
- i_areset asserted mid-W of burst 2, then i_start again -> all outputs at reset values next edge; the rerun restarts at address 8 with data 1.

Source files
------------

// File: rtl/sram_axi4_pkg.sv
// Shared types and AXI4 constants for the SRAM AXI4 traffic generator.
package sram_axi4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_NEXT = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    MODE_WR    = 2'd0,
    MODE_RD    = 2'd1,
    MODE_WR_RD = 2'd2,
    MODE_ILV   = 2'd3
  } mode_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI size field: log2 of the number of bytes per beat.
  function automatic logic [2:0] axi_size(input int dataW);
    return 3'($clog2(dataW / 8));
  endfunction

endpackage

// File: rtl/sram_axi4_tg_gen.sv
// Burst/beat index keeper; derives the burst address and the pattern data
// (global beat index + 1) used by both the write and the read-check paths.
module sram_axi4_tg_gen
  import sram_axi4_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int NUM_XFER  = 4,
  parameter int BASE_ADDR = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              xferClr_i,
  input  logic              xferInc_i,
  input  logic              beatInc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              lastBeat_o,
  output logic              lastXfer_o
);

  localparam int TW = (NUM_XFER > 1) ? $clog2(NUM_XFER) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [TW-1:0] xferIdx_q, xferIdx_d;
  logic [BW-1:0] beatIdx_q, beatIdx_d;

  assign lastBeat_o = (beatIdx_q == BW'(BURST_LEN - 1));
  assign lastXfer_o = (xferIdx_q == TW'(NUM_XFER - 1));

  assign addr_o = ADDR_W'(32'(BASE_ADDR) + 32'(xferIdx_q) * 32'(BURST_LEN * (DATA_W / 8)));
  assign data_o = DATA_W'(32'(xferIdx_q) * 32'(BURST_LEN) + 32'(beatIdx_q) + 32'd1);

  // Next transfer/beat index; the beat counter wraps at the end of each burst.
  always_comb begin
    xferIdx_d = xferIdx_q;
    beatIdx_d = beatIdx_q;
    if (xferClr_i) begin
      xferIdx_d = '0;
      beatIdx_d = '0;
    end else begin
      if (xferInc_i) xferIdx_d = xferIdx_q + 1'b1;
      if (beatInc_i) beatIdx_d = lastBeat_o ? '0 : beatIdx_q + 1'b1;
    end
  end

  // Index registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      xferIdx_q <= '0;
      beatIdx_q <= '0;
    end else begin
      xferIdx_q <= xferIdx_d;
      beatIdx_q <= beatIdx_d;
    end
  end

endmodule

// File: rtl/sram_axi4_tg.sv
// AXI4 master traffic generator: writes incrementing bursts of a known
// pattern, reads them back, counts mismatches and flags bad responses.
module sram_axi4_tg
  import sram_axi4_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4,
  parameter int NUM_XFER  = 4,
  parameter int BASE_ADDR = 8
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  output logic [ADDR_W-1:0]     o_awaddr,
  output logic [7:0]            o_awlen,
  output logic [2:0]            o_awsize,
  output logic [1:0]            o_awburst,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  output logic                  o_wlast,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  input  logic [1:0]            i_bresp,
  output logic                  o_bready,
  output logic [ADDR_W-1:0]     o_araddr,
  output logic [7:0]            o_arlen,
  output logic [2:0]            o_arsize,
  output logic [1:0]            o_arburst,
  output logic                  o_arvalid,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  input  logic [DATA_W-1:0]     i_rdata,
  input  logic [1:0]            i_rresp,
  input  logic                  i_rlast,
  output logic                  o_rready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_err_cnt,
  output logic                  o_resp_err
);

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic        rdPhase_q, rdPhase_d;
  logic [15:0] errCnt_q, errCnt_d;
  logic        respErr_q, respErr_d;

  logic              xferClr, xferInc, beatInc;
  logic [ADDR_W-1:0] genAddr;
  logic [DATA_W-1:0] genData;
  logic              lastBeat, lastXfer;
  logic              dataMiss, lastMiss;
  logic [16:0]       errSum;

  sram_axi4_tg_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .NUM_XFER(NUM_XFER), .BASE_ADDR(BASE_ADDR)
  ) u_gen (
    .clk_i(i_aclk), .reset_i(i_areset),
    .xferClr_i(xferClr), .xferInc_i(xferInc), .beatInc_i(beatInc),
    .addr_o(genAddr), .data_o(genData),
    .lastBeat_o(lastBeat), .lastXfer_o(lastXfer)
  );

  assign dataMiss = (i_rdata != genData);
  assign lastMiss = (i_rlast != lastBeat);
  assign errSum   = {1'b0, errCnt_q} + {16'd0, dataMiss} + {16'd0, lastMiss};

  // Run sequencing: channel handshakes, read checking and burst stepping.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rdPhase_d = rdPhase_q;
    errCnt_d  = errCnt_q;
    respErr_d = respErr_q;
    xferClr   = 1'b0;
    xferInc   = 1'b0;
    beatInc   = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) begin
        mode_d    = mode_e'(i_mode);
        rdPhase_d = 1'b0;
        errCnt_d  = '0;
        respErr_d = 1'b0;
        xferClr   = 1'b1;
        state_d   = (mode_e'(i_mode) == MODE_RD) ? ST_AR : ST_AW;
      end
      ST_AW: if (i_awready) state_d = ST_W;
      ST_W: if (i_wready) begin
        beatInc = 1'b1;
        if (lastBeat) state_d = ST_B;
      end
      ST_B: if (i_bvalid) begin
        if (i_bresp != AXI_RESP_OKAY) respErr_d = 1'b1;
        if (mode_q == MODE_ILV)                state_d = ST_AR;
        else if (mode_q == MODE_WR && lastXfer) state_d = ST_DONE;
        else                                   state_d = ST_NEXT;
      end
      ST_AR: if (i_arready) state_d = ST_R;
      ST_R: if (i_rvalid) begin
        beatInc = 1'b1;
        if (i_rresp != AXI_RESP_OKAY) respErr_d = 1'b1;
        errCnt_d = errSum[16] ? 16'hFFFF : errSum[15:0];
        if (lastBeat) state_d = lastXfer ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: begin
        if (mode_q == MODE_WR_RD && !rdPhase_q && lastXfer) begin
          xferClr   = 1'b1;
          rdPhase_d = 1'b1;
          state_d   = ST_AR;
        end else begin
          xferInc = 1'b1;
          state_d = (mode_q == MODE_RD || rdPhase_q) ? ST_AR : ST_AW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_WR;
      rdPhase_q <= 1'b0;
      errCnt_q  <= '0;
      respErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      rdPhase_q <= rdPhase_d;
      errCnt_q  <= errCnt_d;
      respErr_q <= respErr_d;
    end
  end

  assign o_awvalid = (state_q == ST_AW);
  assign o_awaddr  = o_awvalid ? genAddr : '0;
  assign o_awlen   = o_awvalid ? 8'(BURST_LEN - 1) : 8'd0;
  assign o_awsize  = o_awvalid ? axi_size(DATA_W) : 3'd0;
  assign o_awburst = o_awvalid ? AXI_BURST_INCR : 2'd0;

  assign o_wvalid = (state_q == ST_W);
  assign o_wdata  = o_wvalid ? genData : '0;
  assign o_wstrb  = {(DATA_W/8){o_wvalid}};
  assign o_wlast  = o_wvalid & lastBeat;
  assign o_bready = (state_q == ST_B);

  assign o_arvalid = (state_q == ST_AR);
  assign o_araddr  = o_arvalid ? genAddr : '0;
  assign o_arlen   = o_arvalid ? 8'(BURST_LEN - 1) : 8'd0;
  assign o_arsize  = o_arvalid ? axi_size(DATA_W) : 3'd0;
  assign o_arburst = o_arvalid ? AXI_BURST_INCR : 2'd0;
  assign o_rready  = (state_q == ST_R);

  assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done     = (state_q == ST_DONE);
  assign o_err_cnt  = errCnt_q;
  assign o_resp_err = respErr_q;

endmodule

// File: tb/tb_sram_axi4_tg.sv
// Bench for sram_axi4_tg: an SRAM slave model with optional backpressure and
// fault injection, plus a transaction-level model of the expected traffic.
module tb_sram_axi4_tg;

  localparam int ADDR_W = 8, DATA_W = 64, BURST_LEN = 4, NUM_XFER = 4, BASE_ADDR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_areset, i_start;
  logic [1:0]        i_mode;
  logic [ADDR_W-1:0] o_awaddr, o_araddr;
  logic [7:0]        o_awlen, o_arlen;
  logic [2:0]        o_awsize, o_arsize;
  logic [1:0]        o_awburst, o_arburst;
  logic              o_awvalid, i_awready, o_arvalid, i_arready;
  logic [DATA_W-1:0] o_wdata, i_rdata;
  logic [7:0]        o_wstrb;
  logic              o_wlast, o_wvalid, i_wready;
  logic              i_bvalid, o_bready, i_rvalid, i_rlast, o_rready;
  logic [1:0]        i_bresp, i_rresp;
  logic              o_busy, o_done, o_resp_err;
  logic [15:0]       o_err_cnt;

  sram_axi4_tg #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .NUM_XFER(NUM_XFER), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .i_aclk(clk), .i_areset(i_areset), .i_start(i_start), .i_mode(i_mode),
    .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .o_rready(o_rready),
    .o_busy(o_busy), .o_done(o_done), .o_err_cnt(o_err_cnt), .o_resp_err(o_resp_err)
  );

  int checks = 0, errors = 0;

  // Slave memory and transaction-level expectations.
  logic [63:0] mem [0:31];
  int  wrIdx, wrBeat, bCnt, rdIdx, rdBeat, wAddrWord, rAddrWord;
  bit  bPend, rdActive;
  int  expErr, doneCnt, cyc, lastHs, curMode;
  bit  expRespErr, bp;
  int  corruptBeat = -1, brespErrBurst = -1, earlyRlastBeat = -1;
  bit  awHeld, arHeld, wHeld;
  logic [63:0] awHeldAddr, arHeldAddr, wHeldData;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] expAddr(input int t);
    return 64'((BASE_ADDR + t * BURST_LEN * (DATA_W / 8)) % 256);
  endfunction

  task automatic modelClear();
    wrIdx = 0; wrBeat = 0; bCnt = 0; rdIdx = 0; rdBeat = 0;
    bPend = 0; rdActive = 0; expErr = 0; expRespErr = 0; doneCnt = 0;
    awHeld = 0; arHeld = 0; wHeld = 0;
  endtask

  task automatic slaveReset();
    modelClear();
    i_awready = 0; i_wready = 0; i_arready = 0;
    i_bvalid = 0; i_bresp = 0;
    i_rvalid = 0; i_rdata = '0; i_rresp = 0; i_rlast = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_awvalid"}, o_awvalid, 0);
    checkOutput({tag, "_awaddr"},  o_awaddr, 0);
    checkOutput({tag, "_awlen"},   o_awlen, 0);
    checkOutput({tag, "_awsize"},  o_awsize, 0);
    checkOutput({tag, "_awburst"}, o_awburst, 0);
    checkOutput({tag, "_wvalid"},  o_wvalid, 0);
    checkOutput({tag, "_wdata"},   o_wdata, 0);
    checkOutput({tag, "_wstrb"},   o_wstrb, 0);
    checkOutput({tag, "_wlast"},   o_wlast, 0);
    checkOutput({tag, "_bready"},  o_bready, 0);
    checkOutput({tag, "_arvalid"}, o_arvalid, 0);
    checkOutput({tag, "_araddr"},  o_araddr, 0);
    checkOutput({tag, "_arlen"},   o_arlen, 0);
    checkOutput({tag, "_rready"},  o_rready, 0);
    checkOutput({tag, "_busy"},    o_busy, 0);
    checkOutput({tag, "_done"},    o_done, 0);
    checkOutput({tag, "_err_cnt"}, o_err_cnt, 0);
    checkOutput({tag, "_resp_err"}, o_resp_err, 0);
  endtask

  // Per-cycle result checks: error counter and response flag track the model,
  // and a done pulse lands exactly one cycle after the final handshake.
  task automatic monitor();
    checkOutput("err_cnt", o_err_cnt, 64'(expErr));
    checkOutput("resp_err", o_resp_err, expRespErr);
    if (o_done) begin
      doneCnt++;
      checkOutput("done_timing", 64'(cyc), 64'(lastHs + 1));
      checkOutput("busy_at_done", o_busy, 0);
    end
  endtask

  // One slave cycle, evaluated at the negative edge: the values seen now are
  // what the DUT presents at the next rising edge.
  task automatic slaveStep();
    int k;
    logic [63:0] d;
    bit lastExp;
    // R channel
    if (rdActive) begin
      i_rvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      k = rdIdx * BURST_LEN + rdBeat;
      d = mem[(rAddrWord + rdBeat) % 32];
      if (k == corruptBeat) d = 64'd0;
      lastExp = (rdBeat == BURST_LEN - 1);
      i_rdata = d; i_rresp = 2'b00;
      i_rlast = lastExp || (k == earlyRlastBeat);
      if (i_rvalid && o_rready) begin
        expErr += ((d != 64'(k + 1)) ? 1 : 0) + ((i_rlast != lastExp) ? 1 : 0);
        if (expErr > 65535) expErr = 65535;
        lastHs = cyc;
        rdBeat++;
        if (rdBeat == BURST_LEN) begin rdActive = 0; rdIdx++; end
      end
    end else begin
      i_rvalid = 0; i_rlast = 0; i_rdata = '0; i_rresp = 0;
    end
    // B channel
    i_bvalid = bPend;
    i_bresp  = (bCnt == brespErrBurst) ? 2'b10 : 2'b00;
    if (i_bvalid && o_bready) begin
      bPend = 0;
      if (i_bresp != 2'b00) expRespErr = 1;
      bCnt++;
      lastHs = cyc;
    end
    // AR channel
    i_arready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (arHeld) begin
      checkOutput("ar_hold_valid", o_arvalid, 1);
      checkOutput("ar_hold_addr", o_araddr, arHeldAddr);
    end
    arHeld = 0;
    if (o_arvalid) begin
      if (!i_arready) begin
        arHeld = 1; arHeldAddr = 64'(o_araddr);
      end else begin
        checkOutput("araddr", o_araddr, expAddr(rdIdx));
        checkOutput("arlen", o_arlen, BURST_LEN - 1);
        checkOutput("arsize", o_arsize, 3);
        checkOutput("arburst", o_arburst, 1);
        checkOutput("ar_order", 64'(bCnt),
                    (curMode == 1) ? 64'd0 : (curMode == 2) ? 64'(NUM_XFER) :
                    (curMode == 3) ? 64'(rdIdx + 1) : 64'hFFFF);
        rAddrWord = int'(o_araddr) >> 3;
        rdActive = 1; rdBeat = 0;
      end
    end
    // W channel
    i_wready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (wHeld) begin
      checkOutput("w_hold_valid", o_wvalid, 1);
      checkOutput("w_hold_data", o_wdata, wHeldData);
    end
    wHeld = 0;
    if (o_wvalid) begin
      if (!i_wready) begin
        wHeld = 1; wHeldData = o_wdata;
      end else begin
        checkOutput("wdata", o_wdata, 64'(wrIdx * BURST_LEN + wrBeat + 1));
        checkOutput("wlast", o_wlast, wrBeat == BURST_LEN - 1);
        checkOutput("wstrb", o_wstrb, 8'hFF);
        mem[(wAddrWord + wrBeat) % 32] = o_wdata;
        wrBeat++;
        if (wrBeat == BURST_LEN) begin wrIdx++; wrBeat = 0; bPend = 1; end
      end
    end
    // AW channel
    i_awready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (awHeld) begin
      checkOutput("aw_hold_valid", o_awvalid, 1);
      checkOutput("aw_hold_addr", o_awaddr, awHeldAddr);
    end
    awHeld = 0;
    if (o_awvalid) begin
      if (!i_awready) begin
        awHeld = 1; awHeldAddr = 64'(o_awaddr);
      end else begin
        checkOutput("awaddr", o_awaddr, expAddr(wrIdx));
        checkOutput("awlen", o_awlen, BURST_LEN - 1);
        checkOutput("awsize", o_awsize, 3);
        checkOutput("awburst", o_awburst, 1);
        if (curMode == 3) checkOutput("aw_order", 64'(rdIdx), 64'(wrIdx));
        wAddrWord = int'(o_awaddr) >> 3;
        wrBeat = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    slaveStep();
  endtask

  // Start one run in the given mode and wait for its done pulse.
  task automatic applyStimulus(input int mode, input bit bpIn, input bit pokeStart,
                               input int expErrCnt, input bit expResp);
    int budget;
    bp = bpIn; curMode = mode;
    modelClear();
    i_mode = 2'(mode); i_start = 1;
    tick();
    i_start = 0;
    checkOutput("busy_after_start", o_busy, 1);
    checkOutput("awvalid_after_start", o_awvalid, mode != 1);
    checkOutput("arvalid_after_start", o_arvalid, mode == 1);
    budget = 0;
    while (doneCnt == 0 && budget < 3000) begin
      tick();
      budget++;
      if (pokeStart && doneCnt == 0) i_start = ($urandom_range(0, 7) == 0);
    end
    i_start = 0;
    checkOutput("done_seen", 64'(doneCnt), 1);
    repeat (3) tick();
    checkOutput("done_once", 64'(doneCnt), 1);
    checkOutput("busy_idle", o_busy, 0);
    checkOutput("bursts_written", 64'(wrIdx), (mode == 1) ? 0 : NUM_XFER);
    checkOutput("bursts_read", 64'(rdIdx), (mode == 0) ? 0 : NUM_XFER);
    checkOutput("err_cnt_final", o_err_cnt, 64'(expErrCnt));
    checkOutput("resp_err_final", o_resp_err, expResp);
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    cyc = 0; lastHs = -10; curMode = 0; bp = 0;
    i_areset = 1; i_start = 0; i_mode = 0;
    slaveReset();
    repeat (3) tick();
    checkResetOutputs("reset");
    i_areset = 0;
    tick();

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0);
    applyStimulus(2, 1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);

    corruptBeat = 6;
    applyStimulus(3, 0, 0, 1, 0);
    corruptBeat = -1;

    brespErrBurst = 1; earlyRlastBeat = 2;
    applyStimulus(2, 0, 0, 1, 1);
    brespErrBurst = -1; earlyRlastBeat = -1;

    // Reset in the middle of the third write burst, then rerun from scratch.
    bp = 0; curMode = 0;
    modelClear();
    i_mode = 2'd0; i_start = 1;
    tick();
    i_start = 0;
    budget = 0;
    while (!(wrIdx == 2 && wrBeat == 2) && budget < 200) begin
      tick();
      budget++;
    end
    checkOutput("reached_burst2", 64'(wrIdx), 2);
    i_areset = 1;
    slaveReset();
    tick();
    checkResetOutputs("midreset");
    i_areset = 0;
    tick();
    applyStimulus(0, 0, 0, 0, 0);

    repeat (4) applyStimulus(int'($urandom_range(0, 3)), 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
